rmt_stage_link: RTL

Parametrised elastic link between the engines of an RMT stage (key extractor → lookup engine → action engine) and between consecutive stages. It carries a PHV, an auxiliary word (key or action bundle) and the VLAN side-channel as one bundle through DEPTH full-throughput skid slices with true valid/ready backpressure. A synchronous flush and optional traffic statistics are included. It replaces the unconditional, ready-blind inter-engine registers.

---
 rtl/rmt_pkg.sv | 25 ++
 rtl/rmt_skid_slice.sv | 80 ++++++++
 rtl/rmt_stage_link.sv | 109 ++++++++++
 3 files changed

// File: rtl/rmt_pkg.sv
// rtl/rmt_pkg.sv - shared widths, skid slice state encoding and stats macro name for the RMT stage link
package rmt_pkg;

    localparam int PHV_LEN        = 1024;
    localparam int KEY_LEN        = 193;
    localparam int C_VLANID_WIDTH = 12;

    // Defining this macro enables the traffic statistics counters.
    localparam string STATS_MACRO = "RMT_STAGE_LINK_STATS_EN";

    typedef enum logic [1:0] {
        SLICE_EMPTY = 2'd0,
        SLICE_ONE   = 2'd1,
        SLICE_TWO   = 2'd2
    } slice_state_e;

    function automatic logic [1:0] slice_count(input slice_state_e s);
        case (s)
            SLICE_ONE: return 2'd1;
            SLICE_TWO: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rmt_skid_slice.sv
// rtl/rmt_skid_slice.sv - one full-throughput main+skid register slice with registered upstream ready
module rmt_skid_slice
    import rmt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count_next
);

    slice_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push, pop;

    // Ready depends only on the held state, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != SLICE_TWO);
    assign out_valid = (state_q != SLICE_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SLICE_EMPTY: begin
                if (push) begin
                    main_d  = in_data;
                    state_d = SLICE_ONE;
                end
            end
            SLICE_ONE: begin
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    skid_d  = in_data;
                    state_d = SLICE_TWO;
                end else if (pop) begin
                    state_d = SLICE_EMPTY;
                end
            end
            SLICE_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = SLICE_ONE;
                end
            end
            default: state_d = SLICE_EMPTY;
        endcase
        if (flush) begin
            state_d = SLICE_EMPTY;
        end
    end

    assign count_next = slice_count(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLICE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/rmt_stage_link.sv
// rtl/rmt_stage_link.sv - elastic PHV/aux/VLAN link of DEPTH skid slices; stats under RMT_STAGE_LINK_STATS_EN
module rmt_stage_link #(
    parameter int DATA_WIDTH     = rmt_pkg::PHV_LEN,
    parameter int AUX_WIDTH      = rmt_pkg::KEY_LEN,
    parameter int C_VLANID_WIDTH = rmt_pkg::C_VLANID_WIDTH,
    parameter int DEPTH          = 2,
    parameter int CNT_WIDTH      = 32,
    localparam int OCC_W         = $clog2(2*DEPTH+1)
) (
    input  logic                      axis_clk,
    input  logic                      areset,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [AUX_WIDTH-1:0]      in_aux,
    input  logic [C_VLANID_WIDTH-1:0] in_vlan,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [AUX_WIDTH-1:0]      out_aux,
    output logic [C_VLANID_WIDTH-1:0] out_vlan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OCC_W-1:0]          occupancy,
    output logic [CNT_WIDTH-1:0]      stat_in_cnt,
    output logic [CNT_WIDTH-1:0]      stat_out_cnt,
    output logic [CNT_WIDTH-1:0]      stat_stall_cnt
);

    localparam int W = DATA_WIDTH + AUX_WIDTH + C_VLANID_WIDTH;

    logic [W-1:0]     link_data  [DEPTH+1];
    logic             link_valid [DEPTH+1];
    logic             link_ready [DEPTH+1];
    logic [1:0]       cnt_next   [DEPTH];
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    // Slice 0 is also told about flush through its own input, so nothing lands in it that cycle.
    assign link_data[0]      = {in_data, in_aux, in_vlan};
    assign link_valid[0]     = in_valid && !flush;
    assign in_ready          = link_ready[0] && !areset && !flush;
    assign link_ready[DEPTH] = out_ready;
    assign out_valid         = link_valid[DEPTH];
    assign {out_data, out_aux, out_vlan} = link_data[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        rmt_skid_slice #(.WIDTH(W)) u_slice (
            .clk        (axis_clk),
            .rst        (areset),
            .flush      (flush),
            .in_data    (link_data[i]),
            .in_valid   (link_valid[i]),
            .in_ready   (link_ready[i]),
            .out_data   (link_data[i+1]),
            .out_valid  (link_valid[i+1]),
            .out_ready  (link_ready[i+1]),
            .count_next (cnt_next[i])
        );
    end

    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(cnt_next[i]);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;

`ifdef RMT_STAGE_LINK_STATS_EN
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        in_cnt_d    = in_cnt_q    + CNT_WIDTH'(in_valid && in_ready);
        out_cnt_d   = out_cnt_q   + CNT_WIDTH'(out_valid && out_ready);
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(out_valid && !out_ready);
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_in_cnt    = in_cnt_q;
    assign stat_out_cnt   = out_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_in_cnt    = '0;
    assign stat_out_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule
